washer_plant: RTL and testbench

WASHER_PLANT -- requirements
Module: washer_plant

---
 rtl/washer_plant.sv | 122 ++++++++++++
 tb/tb_washer_plant.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/washer_plant.sv
// Washing-machine plant model: water level, laundry moisture and wash timing driven by controller commands.
// Optional WASHER_PLANT_LEAK_EN adds a `leak` input that drains one level unit per cycle outside HALT.
module washer_plant #(
  parameter int LEVEL_MAX  = 15,
  parameter int FILL_STEP  = 1,
  parameter int DRAIN_STEP = 1,
  parameter int MOIST_MAX  = 12,
  parameter int SPIN_STEP  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             water_fill,
  input  logic                             motor_wash,
  input  logic                             motor_spin,
  input  logic                             drain,
  input  logic                             fault,
`ifdef WASHER_PLANT_LEAK_EN
  input  logic                             leak,
`endif
  output logic                             water_full,
  output logic                             drained,
  output logic                             dry_sensor,
  output logic [$clog2(LEVEL_MAX+1)-1:0]   level,
  output logic [2:0]                       mode,
  output logic                             cmd_err,
  output logic [15:0]                      wash_cycles
);

  localparam int LW = $clog2(LEVEL_MAX + 1);
  localparam int MW = $clog2(MOIST_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    DRAIN = 3'd3,
    SPIN  = 3'd4,
    HALT  = 3'd5
  } mode_e;

  mode_e          mode_q, mode_d;
  logic [LW-1:0]  level_q, level_d;
  logic [MW-1:0]  moist_q, moist_d;
  logic           err_q, err_d;
  logic [15:0]    wash_q, wash_d;
  logic [2:0]     n_cmd;
  logic           illegal;
  int             lvl;

  // The datapath acts on the decoded next mode so a command takes effect on the same edge it is registered.
  always_comb begin
    n_cmd   = 3'(water_fill) + 3'(motor_wash) + 3'(motor_spin) + 3'(drain);
    illegal = (water_fill & drain) | (motor_wash & motor_spin) | (n_cmd > 3'd2);
    mode_d  = IDLE;
    if (fault) begin
      mode_d = HALT;
    end else if (mode_q == HALT && n_cmd != 3'd0) begin
      mode_d = HALT;
    end else if (!illegal && n_cmd == 3'd1) begin
      if (water_fill)      mode_d = FILL;
      else if (drain)      mode_d = DRAIN;
      else if (motor_wash) mode_d = WASH;
      else                 mode_d = SPIN;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    level_d = level_q;
    moist_d = moist_q;
    err_d   = err_q;
    wash_d  = wash_q;
    lvl     = int'(level_q);
    if (mode_d != HALT) begin
      err_d = err_q | illegal;
      case (mode_d)
        FILL:  lvl = (lvl + FILL_STEP > LEVEL_MAX) ? LEVEL_MAX : lvl + FILL_STEP;
        DRAIN: lvl = (lvl < DRAIN_STEP) ? 0 : lvl - DRAIN_STEP;
        WASH: begin
          if (level_q == '0) err_d = 1'b1;
          if (wash_q != 16'hFFFF) wash_d = wash_q + 16'd1;
        end
        SPIN: begin
          if (level_q != '0) err_d = 1'b1;
          else moist_d = (int'(moist_q) < SPIN_STEP) ? '0 : moist_q - MW'(SPIN_STEP);
        end
        default: ;
      endcase
`ifdef WASHER_PLANT_LEAK_EN
      if (leak && lvl > 0) lvl = lvl - 1;
`endif
      level_d = LW'(lvl);
      // Any standing water re-soaks the laundry.
      if (level_q != '0) moist_d = MW'(MOIST_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= IDLE;
      level_q <= '0;
      moist_q <= '0;
      err_q   <= 1'b0;
      wash_q  <= 16'd0;
    end else begin
      mode_q  <= mode_d;
      level_q <= level_d;
      moist_q <= moist_d;
      err_q   <= err_d;
      wash_q  <= wash_d;
    end
  end

  assign water_full  = (level_q == LW'(LEVEL_MAX));
  assign drained     = (level_q == '0);
  assign dry_sensor  = (moist_q == '0);
  assign level       = level_q;
  assign mode        = mode_q;
  assign cmd_err     = err_q;
  assign wash_cycles = wash_q;

endmodule

// File: tb/tb_washer_plant.sv
// Self-checking bench for washer_plant: directed scenarios plus randomized commands against a behavioural model.
module tb_washer_plant;

  localparam int LEVEL_MAX  = 15;
  localparam int FILL_STEP  = 1;
  localparam int DRAIN_STEP = 1;
  localparam int MOIST_MAX  = 12;
  localparam int SPIN_STEP  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic water_fill = 1'b0, motor_wash = 1'b0, motor_spin = 1'b0, drain = 1'b0, fault = 1'b0;
  logic leak = 1'b0;
  logic water_full, drained, dry_sensor, cmd_err;
  logic [3:0]  level;
  logic [2:0]  mode;
  logic [15:0] wash_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_level, m_moist, m_mode, m_wash;
  bit m_err;

  always #5 clk = ~clk;

  washer_plant #(
    .LEVEL_MAX(LEVEL_MAX), .FILL_STEP(FILL_STEP), .DRAIN_STEP(DRAIN_STEP),
    .MOIST_MAX(MOIST_MAX), .SPIN_STEP(SPIN_STEP)
  ) dut (
    .clk(clk), .rst(rst),
    .water_fill(water_fill), .motor_wash(motor_wash), .motor_spin(motor_spin),
    .drain(drain), .fault(fault),
`ifdef WASHER_PLANT_LEAK_EN
    .leak(leak),
`endif
    .water_full(water_full), .drained(drained), .dry_sensor(dry_sensor),
    .level(level), .mode(mode), .cmd_err(cmd_err), .wash_cycles(wash_cycles)
  );

  task automatic model_reset();
    m_level = 0; m_moist = 0; m_mode = 0; m_wash = 0; m_err = 0;
  endtask

  task automatic model_step();
    int n, nm, old;
    bit bad;
    n   = int'(water_fill) + int'(motor_wash) + int'(motor_spin) + int'(drain);
    bad = (water_fill && drain) || (motor_wash && motor_spin) || (n > 2);
    if (fault)                    nm = 5;
    else if (m_mode == 5 && n > 0) nm = 5;
    else if (bad) begin nm = 0; m_err = 1; end
    else if (n == 1)              nm = water_fill ? 1 : drain ? 3 : motor_wash ? 2 : 4;
    else                          nm = 0;
    m_mode = nm;
    if (nm == 5) return;
    old = m_level;
    if (nm == 1) m_level = (m_level + FILL_STEP > LEVEL_MAX) ? LEVEL_MAX : m_level + FILL_STEP;
    if (nm == 3) m_level = (m_level < DRAIN_STEP) ? 0 : m_level - DRAIN_STEP;
    if (nm == 2) begin
      if (old == 0) m_err = 1;
      if (m_wash < 65535) m_wash++;
    end
    if (nm == 4) begin
      if (old != 0) m_err = 1;
      else m_moist = (m_moist < SPIN_STEP) ? 0 : m_moist - SPIN_STEP;
    end
`ifdef WASHER_PLANT_LEAK_EN
    if (leak && m_level > 0) m_level--;
`endif
    if (old != 0) m_moist = MOIST_MAX;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic cmd(input logic f, input logic w, input logic s, input logic d, input logic flt);
    water_fill = f; motor_wash = w; motor_spin = s; drain = d; fault = flt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd(0, 0, 0, 0, 0);
    #2;
    n_checks++;
    if ({level, mode, cmd_err, wash_cycles} !== {4'd0, 3'd0, 1'b0, 16'd0}) begin
      n_fail++; $display("FAIL reset_state: got lvl=%0d mode=%0d err=%0b wash=%0d, want all 0", level, mode, cmd_err, wash_cycles);
    end
    n_checks++;
    if ({water_full, drained, dry_sensor} !== 3'b011) begin
      n_fail++; $display("FAIL reset_flags: got full/drained/dry=%b want 011", {water_full, drained, dry_sensor});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_full_fill();
    cmd(1, 0, 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      n_checks++;
      if (level !== 4'(i)) begin
        n_fail++; $display("FAIL fill_level cycle %0d: got %0d want %0d", i, level, i);
      end
      if (i == 14) begin
        n_checks++;
        if (water_full !== 1'b0) begin
          n_fail++; $display("FAIL fill_full_early: got %0b want 0", water_full);
        end
      end
    end
    n_checks++;
    if ({water_full, dry_sensor, mode} !== {1'b1, 1'b0, 3'd1}) begin
      n_fail++; $display("FAIL fill_done: got full=%0b dry=%0b mode=%0d want 1 0 1", water_full, dry_sensor, mode);
    end
    tick(); tick();
    n_checks++;
    if (level !== 4'd15) begin
      n_fail++; $display("FAIL fill_saturate: got %0d want 15", level);
    end
  endtask

  task automatic test_drain_spin();
    cmd(0, 0, 0, 1, 0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 14) begin
        n_checks++;
        if ({drained, level} !== {1'b0, 4'd1}) begin
          n_fail++; $display("FAIL drain_early: got drained=%0b lvl=%0d want 0 1", drained, level);
        end
      end
    end
    n_checks++;
    if ({drained, level, dry_sensor} !== {1'b1, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL drain_done: got drained=%0b lvl=%0d dry=%0b want 1 0 0", drained, level, dry_sensor);
    end
    cmd(0, 0, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 11) begin
        n_checks++;
        if (dry_sensor !== 1'b0) begin
          n_fail++; $display("FAIL spin_dry_early: got %0b want 0", dry_sensor);
        end
      end
    end
    n_checks++;
    if ({dry_sensor, mode, cmd_err} !== {1'b1, 3'd4, 1'b0}) begin
      n_fail++; $display("FAIL spin_done: got dry=%0b mode=%0d err=%0b want 1 4 0", dry_sensor, mode, cmd_err);
    end
    tick(); tick();
    n_checks++;
    if ({dry_sensor, level} !== {1'b1, 4'd0}) begin
      n_fail++; $display("FAIL spin_saturate: got dry=%0b lvl=%0d want 1 0", dry_sensor, level);
    end
  endtask

  task automatic test_illegal();
    cmd(1, 0, 0, 0, 0);
    repeat (5) tick();
    cmd(1, 0, 0, 1, 0);
    tick();
    n_checks++;
    if ({mode, level, cmd_err} !== {3'd0, 4'd5, 1'b1}) begin
      n_fail++; $display("FAIL illegal_cmd: got mode=%0d lvl=%0d err=%0b want 0 5 1", mode, level, cmd_err);
    end
    cmd(0, 0, 0, 0, 0);
    tick(); tick();
    n_checks++;
    if ({mode, level, cmd_err} !== {3'd0, 4'd5, 1'b1}) begin
      n_fail++; $display("FAIL illegal_sticky: got mode=%0d lvl=%0d err=%0b want 0 5 1", mode, level, cmd_err);
    end
  endtask

  task automatic test_fault_hold();
    cmd(1, 0, 0, 0, 0);
    tick(); tick();
    cmd(1, 0, 0, 0, 1);
    tick();
    n_checks++;
    if ({mode, level} !== {3'd5, 4'd7}) begin
      n_fail++; $display("FAIL fault_enter: got mode=%0d lvl=%0d want 5 7", mode, level);
    end
    tick();
    cmd(1, 0, 0, 0, 0);
    tick();
    n_checks++;
    if ({mode, level} !== {3'd5, 4'd7}) begin
      n_fail++; $display("FAIL fault_persist: got mode=%0d lvl=%0d want 5 7", mode, level);
    end
    cmd(0, 1, 0, 0, 0);
    tick();
    n_checks++;
    if ({mode, level, wash_cycles} !== {3'd5, 4'd7, 16'd0}) begin
      n_fail++; $display("FAIL fault_wash_held: got mode=%0d lvl=%0d wash=%0d want 5 7 0", mode, level, wash_cycles);
    end
    cmd(0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (mode !== 3'd0) begin
      n_fail++; $display("FAIL fault_exit: got mode=%0d want 0", mode);
    end
    cmd(1, 0, 0, 0, 0);
    tick();
    n_checks++;
    if ({mode, level} !== {3'd1, 4'd8}) begin
      n_fail++; $display("FAIL fault_resume: got mode=%0d lvl=%0d want 1 8", mode, level);
    end
  endtask

  task automatic test_wash_reset();
    cmd(1, 0, 0, 0, 0);
    repeat (10) tick();
    cmd(0, 1, 0, 0, 0);
    repeat (10) tick();
    n_checks++;
    if ({wash_cycles, level, mode} !== {16'd10, 4'd15, 3'd2}) begin
      n_fail++; $display("FAIL wash_count: got wash=%0d lvl=%0d mode=%0d want 10 15 2", wash_cycles, level, mode);
    end
    cmd(0, 0, 0, 1, 0);
    repeat (4) tick();
    cmd(1, 0, 0, 0, 0);
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({level, mode, cmd_err, wash_cycles, water_full, drained, dry_sensor} !==
        {4'd0, 3'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL async_reset: got lvl=%0d mode=%0d err=%0b wash=%0d flags=%b", level, mode, cmd_err, wash_cycles, {water_full, drained, dry_sensor});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
    n_checks++;
    if ({mode, level, cmd_err} !== {3'd1, 4'd1, 1'b0}) begin
      n_fail++; $display("FAIL post_reset_fill: got mode=%0d lvl=%0d err=%0b want 1 1 0", mode, level, cmd_err);
    end
  endtask

`ifdef WASHER_PLANT_LEAK_EN
  task automatic test_leak();
    cmd(0, 0, 0, 1, 0);
    repeat (16) tick();
    cmd(1, 0, 0, 0, 0);
    repeat (3) tick();
    cmd(1, 0, 0, 0, 0);
    leak = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (level !== 4'd3) begin
      n_fail++; $display("FAIL leak_fill_balance: got %0d want 3", level);
    end
    cmd(0, 0, 0, 0, 0);
    repeat (3) tick();
    n_checks++;
    if (level !== 4'd0) begin
      n_fail++; $display("FAIL leak_alone: got %0d want 0", level);
    end
    leak = 1'b0;
  endtask
`endif

  task automatic test_random();
    int favored;
    favored = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 40 == 0) favored = int'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
      end
      if ($urandom_range(0, 3) == 0) begin
        cmd($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 35,
            $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 6);
      end else begin
        cmd(favored == 0, favored == 2, favored == 3, favored == 1, 1'b0);
      end
`ifdef WASHER_PLANT_LEAK_EN
      leak = ($urandom_range(0, 9) == 0);
`endif
      tick();
      n_checks++;
      if ({level, mode, cmd_err, wash_cycles, water_full, drained, dry_sensor} !==
          {4'(m_level), 3'(m_mode), m_err, 16'(m_wash), m_level == LEVEL_MAX, m_level == 0, m_moist == 0}) begin
        n_fail++;
        $display("FAIL random cycle %0d: got lvl=%0d mode=%0d err=%0b wash=%0d flags=%b want lvl=%0d mode=%0d err=%0b wash=%0d moist=%0d",
                 cyc, level, mode, cmd_err, wash_cycles, {water_full, drained, dry_sensor},
                 m_level, m_mode, m_err, m_wash, m_moist);
      end
    end
    leak = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_full_fill();
    test_drain_spin();
    test_illegal();
    test_fault_hold();
    test_wash_reset();
`ifdef WASHER_PLANT_LEAK_EN
    test_leak();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
